// File: rtl/quiz_controller.sv
// ============================================================================
// quiz_controller -- four-contestant buzzer quiz sequencer with scoring.
// Revision 1.0
// ============================================================================
`default_nettype none

module quiz_controller #(
    parameter int NUM_Q   = 8,
    parameter int SCORE_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [3:0]             buzz_i,
    input  logic                   judge_ok_i,
    input  logic                   judge_bad_i,
    input  logic                   time_up_i,
    output logic                   c_en_o,
    output logic                   cd_load_o,
    output logic [2:0]             state_o,
    output logic [1:0]             winner_o,
    output logic                   winner_valid_o,
    output logic [3:0]             lockout_o,
    output logic [2:0]             q_index_o,
    output logic [4*SCORE_W-1:0]   score_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_QUESTION = 3'd1,
        S_ANSWER   = 3'd2,
        S_REVEAL   = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam logic [2:0]         LAST_Q    = 3'(NUM_Q - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e                 state_q, state_d;
    logic                   cd_load_q, cd_load_d;
    logic [1:0]             winner_q, winner_d;
    logic [3:0]             lockout_q, lockout_d;
    logic [2:0]             q_index_q, q_index_d;
    logic [4*SCORE_W-1:0]   score_q, score_d;
    logic                   start_q;
    logic [3:0]             buzz_q;

    logic                   start_edge;
    logic [3:0]             buzz_valid;
    logic [1:0]             first_buzz;
    logic [SCORE_W-1:0]     cur_score;

    assign start_edge = start_i & ~start_q;
    assign buzz_valid = buzz_i & ~buzz_q & ~lockout_q;
    assign cur_score  = score_q[int'(winner_q) * SCORE_W +: SCORE_W];

    // Descending scan so the lowest-index contestant overrides the others.
    always_comb begin
        first_buzz = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (buzz_valid[i]) begin
                first_buzz = 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cd_load_d = 1'b0;
        winner_d  = winner_q;
        lockout_d = lockout_q;
        q_index_d = q_index_q;
        score_d   = score_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    score_d   = '0;
                    q_index_d = '0;
                    lockout_d = '0;
                    cd_load_d = 1'b1;
                    state_d   = S_QUESTION;
                end
            end
            S_QUESTION: begin
                if (|buzz_valid) begin
                    winner_d = first_buzz;
                    state_d  = S_ANSWER;
                end else if (time_up_i) begin
                    state_d = S_REVEAL;
                end
            end
            S_ANSWER: begin
                if (judge_ok_i) begin
                    if (cur_score != SCORE_MAX) begin
                        score_d[int'(winner_q) * SCORE_W +: SCORE_W] = cur_score + SCORE_W'(1);
                    end
                    state_d = S_REVEAL;
                end else if (judge_bad_i) begin
                    lockout_d[winner_q] = 1'b1;
                    // Resume the paused countdown unless nobody is left to answer.
                    state_d = (&(lockout_q | (4'b0001 << winner_q))) ? S_REVEAL : S_QUESTION;
                end
            end
            S_REVEAL: begin
                if (start_edge) begin
                    if (q_index_q == LAST_Q) begin
                        state_d = S_DONE;
                    end else begin
                        q_index_d = q_index_q + 3'd1;
                        lockout_d = '0;
                        cd_load_d = 1'b1;
                        state_d   = S_QUESTION;
                    end
                end
            end
            S_DONE: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cd_load_q <= 1'b0;
            winner_q  <= 2'd0;
            lockout_q <= 4'd0;
            q_index_q <= 3'd0;
            score_q   <= '0;
            start_q   <= 1'b0;
            buzz_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            cd_load_q <= cd_load_d;
            winner_q  <= winner_d;
            lockout_q <= lockout_d;
            q_index_q <= q_index_d;
            score_q   <= score_d;
            start_q   <= start_i;
            buzz_q    <= buzz_i;
        end
    end

    assign c_en_o         = (state_q == S_QUESTION) && !cd_load_q;
    assign cd_load_o      = cd_load_q;
    assign state_o        = state_q;
    assign winner_o       = winner_q;
    assign winner_valid_o = (state_q == S_ANSWER);
    assign lockout_o      = lockout_q;
    assign q_index_o      = q_index_q;
    assign score_o        = score_q;

endmodule

`default_nettype wire

// File: tb/tb_quiz_controller.sv
// ============================================================================
// tb_quiz_controller -- vector table plus hand sequences, scoreboard checked.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_quiz_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] buzz;
    logic       judge_ok;
    logic       judge_bad;
    logic       time_up;
    logic       c_en;
    logic       cd_load;
    logic [2:0] state;
    logic [1:0] winner;
    logic       winner_valid;
    logic [3:0] lockout;
    logic [2:0] q_index;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quiz_controller #(.NUM_Q(4), .SCORE_W(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .buzz_i         (buzz),
        .judge_ok_i     (judge_ok),
        .judge_bad_i    (judge_bad),
        .time_up_i      (time_up),
        .c_en_o         (c_en),
        .cd_load_o      (cd_load),
        .state_o        (state),
        .winner_o       (winner),
        .winner_valid_o (winner_valid),
        .lockout_o      (lockout),
        .q_index_o      (q_index),
        .score_o        (score)
    );

    typedef struct packed {
        logic       st;
        logic [3:0] bz;
        logic       ok;
        logic       bad;
        logic       tu;
        logic [2:0] es;
        logic       ecen;
        logic       ecdl;
        logic [1:0] ew;
        logic       ewv;
        logic [3:0] elk;
        logic [2:0] eq;
        logic [7:0] esc;
    } vec_t;

    typedef struct packed {
        logic [15:0] tag;
        logic [2:0]  es;
        logic        ecen;
        logic        ecdl;
        logic [1:0]  ew;
        logic        ewv;
        logic [3:0]  elk;
        logic [2:0]  eq;
        logic [7:0]  esc;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    function automatic vec_t v(input logic st, input logic [3:0] bz, input logic ok,
                               input logic bad, input logic tu, input logic [2:0] es,
                               input logic ecen, input logic ecdl, input logic [1:0] ew,
                               input logic ewv, input logic [3:0] elk, input logic [2:0] eq,
                               input logic [7:0] esc);
        return '{st, bz, ok, bad, tu, es, ecen, ecdl, ew, ewv, elk, eq, esc};
    endfunction

    function automatic exp_t to_exp(input vec_t r, input int tag);
        return '{16'(tag), r.es, r.ecen, r.ecdl, r.ew, r.ewv, r.elk, r.eq, r.esc};
    endfunction

    task automatic compare();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected record available");
        end else begin
            e = sb_q.pop_front();
            if (state !== e.es || c_en !== e.ecen || cd_load !== e.ecdl || winner !== e.ew ||
                winner_valid !== e.ewv || lockout !== e.elk || q_index !== e.eq || score !== e.esc) begin
                errors++;
                $display("FAIL step%0d: got st=%0d cen=%b cdl=%b w=%0d wv=%b lk=%b q=%0d sc=%h, want st=%0d cen=%b cdl=%b w=%0d wv=%b lk=%b q=%0d sc=%h",
                         e.tag, state, c_en, cd_load, winner, winner_valid, lockout, q_index, score,
                         e.es, e.ecen, e.ecdl, e.ew, e.ewv, e.elk, e.eq, e.esc);
            end
        end
    endtask

    task automatic run(input vec_t r, input int tag);
        @(negedge clk);
        start     = r.st;
        buzz      = r.bz;
        judge_ok  = r.ok;
        judge_bad = r.bad;
        time_up   = r.tu;
        sb_q.push_back(to_exp(r, tag));
        @(posedge clk);
        #1;
        compare();
    endtask

    int s0;

    initial begin
        rst_n = 1'b0; start = 1'b0; buzz = 4'd0; judge_ok = 1'b0; judge_bad = 1'b0; time_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(to_exp(v(0,0,0,0,0, 3'd0,0,0,2'd0,0,4'h0,3'd0,8'h00), 0));
        compare();
        @(negedge clk);
        rst_n = 1'b1;

        //          st bz       ok bad tu   st   cen cdl w  wv lock     q     score
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'd0, 8'h00));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0000, 3'd0, 8'h00));
        tbl.push_back(v(0, 4'b1010, 0, 0, 0, 3'd2, 0, 0, 2'd1, 1, 4'b0000, 3'd0, 8'h00));
        tbl.push_back(v(0, 4'b0000, 1, 0, 0, 3'd3, 0, 0, 2'd1, 0, 4'b0000, 3'd0, 8'h04));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd1, 0, 4'b0000, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd1, 0, 4'b0000, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0100, 0, 0, 0, 3'd2, 0, 0, 2'd2, 1, 4'b0000, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 1, 0, 3'd1, 1, 0, 2'd2, 0, 4'b0100, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0100, 0, 0, 0, 3'd1, 1, 0, 2'd2, 0, 4'b0100, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd2, 0, 4'b0100, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0001, 0, 0, 0, 3'd2, 0, 0, 2'd0, 1, 4'b0100, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b1000, 0, 0, 1, 3'd2, 0, 0, 2'd0, 1, 4'b0100, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 1, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0101, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b1000, 0, 0, 0, 3'd2, 0, 0, 2'd3, 1, 4'b0101, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 1, 0, 3'd1, 1, 0, 2'd3, 0, 4'b1101, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0010, 0, 0, 0, 3'd2, 0, 0, 2'd1, 1, 4'b1101, 3'd1, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 1, 0, 3'd3, 0, 0, 2'd1, 0, 4'b1111, 3'd1, 8'h04));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd1, 0, 4'b0000, 3'd2, 8'h04));
        tbl.push_back(v(0, 4'b0001, 0, 0, 1, 3'd2, 0, 0, 2'd0, 1, 4'b0000, 3'd2, 8'h04));
        tbl.push_back(v(0, 4'b0000, 1, 1, 0, 3'd3, 0, 0, 2'd0, 0, 4'b0000, 3'd2, 8'h05));
        tbl.push_back(v(0, 4'b0000, 1, 0, 0, 3'd3, 0, 0, 2'd0, 0, 4'b0000, 3'd2, 8'h05));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 3'd3, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd4, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 3'd4, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(0, 4'b0001, 1, 0, 0, 3'd4, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h05));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'd0, 8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], i + 1);
        end

        // Contestant 0 answers every question correctly; score saturates at 3.
        s0 = 0;
        for (int k = 0; k < 4; k++) begin
            run(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0000, 3'(k), 8'(s0)), 100 + 4*k);
            run(v(0, 4'b0001, 0, 0, 0, 3'd2, 0, 0, 2'd0, 1, 4'b0000, 3'(k), 8'(s0)), 101 + 4*k);
            s0 = (s0 == 3) ? 3 : s0 + 1;
            run(v(0, 4'b0000, 1, 0, 0, 3'd3, 0, 0, 2'd0, 0, 4'b0000, 3'(k), 8'(s0)), 102 + 4*k);
            if (k < 3)
                run(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'(k + 1), 8'(s0)), 103 + 4*k);
            else
                run(v(1, 4'b0000, 0, 0, 0, 3'd4, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'(s0)), 103 + 4*k);
        end

        run(v(0, 4'b0000, 0, 0, 0, 3'd4, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h03), 200);
        run(v(1, 4'b0000, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h03), 201);
        run(v(0, 4'b0000, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 4'b0000, 3'd3, 8'h03), 202);
        run(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'd0, 8'h00), 203);
        run(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0000, 3'd0, 8'h00), 204);
        run(v(0, 4'b0001, 0, 0, 0, 3'd2, 0, 0, 2'd0, 1, 4'b0000, 3'd0, 8'h00), 205);
        run(v(0, 4'b0000, 1, 0, 0, 3'd3, 0, 0, 2'd0, 0, 4'b0000, 3'd0, 8'h01), 206);
        run(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'd1, 8'h01), 207);
        run(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0000, 3'd1, 8'h01), 208);
        run(v(0, 4'b0010, 0, 0, 0, 3'd2, 0, 0, 2'd1, 1, 4'b0000, 3'd1, 8'h01), 209);

        // Reset between clock edges while contestant 1 holds the floor.
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(to_exp(v(0,0,0,0,0, 3'd0,0,0,2'd0,0,4'h0,3'd0,8'h00), 210));
        compare();
        @(negedge clk);
        rst_n = 1'b1;

        run(v(0, 4'b0000, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 4'b0000, 3'd0, 8'h00), 211);
        run(v(1, 4'b0000, 0, 0, 0, 3'd1, 0, 1, 2'd0, 0, 4'b0000, 3'd0, 8'h00), 212);
        run(v(0, 4'b0000, 0, 0, 0, 3'd1, 1, 0, 2'd0, 0, 4'b0000, 3'd0, 8'h00), 213);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quiz_controller.md
QUIZ_CONTROLLER -- requirements
Module: quiz_controller

Interface
REQ-001 Parameter NUM_Q, default 8, questions per round (2..8).
REQ-002 Parameter SCORE_W, default 4, per-contestant score width.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 start  input  1  host button, synchronous, one-cycle-pulse semantics (level high counts once per rising edge).
REQ-006 buzz  input  4  contestant buttons, synchronous levels; bit i = contestant i.
REQ-007 judge_ok  input  1  host verdict "correct", single-cycle pulse.
REQ-008 judge_bad  input  1  host verdict "wrong", single-cycle pulse.
REQ-009 time_up  input  1  countdown expiry level from the countdown timer.
REQ-010 C_en  output  1  countdown enable.
REQ-011 cd_load  output  1  one-cycle pulse, reloads countdown to full time.
REQ-012 state  output  3  IDLE=0, QUESTION=1, ANSWER=2, REVEAL=3, DONE=4.
REQ-013 winner  output  2  index of contestant holding the floor; winner_valid output 1 qualifies it.
REQ-014 lockout  output  4  bit i high = contestant i barred for current question.
REQ-015 q_index  output  3  current question number, 0-based.
REQ-016 score  output  4*SCORE_W  packed {s3,s2,s1,s0}.

Function
REQ-017 Rising edges of start and buzz detected by registering previous sample; only edges act.
REQ-018 IDLE: start edge -> scores, q_index, lockout cleared; next state QUESTION; cd_load=1 for exactly the first QUESTION cycle.
REQ-019 QUESTION: C_en=1 in every cycle where cd_load=0; C_en=0 in all other states.
REQ-020 QUESTION: buzz edge from any non-locked contestant -> ANSWER next cycle, winner=lowest-index non-locked contestant with an edge that cycle, winner_valid=1.
REQ-021 QUESTION: buzz edges from locked contestants ignored.
REQ-022 QUESTION: time_up=1 with no valid buzz edge same cycle -> REVEAL; if both, buzz wins.
REQ-023 ANSWER: countdown paused (C_en=0); time_up and buzz ignored.
REQ-024 ANSWER: judge_ok -> s[winner] += 1, saturating at 2^SCORE_W-1; next state REVEAL.
REQ-025 ANSWER: judge_bad -> lockout[winner] set; if all four bits then set -> REVEAL, else QUESTION (no cd_load, countdown resumes).
REQ-026 judge_ok and judge_bad in same cycle: judge_ok wins; verdicts outside ANSWER ignored.
REQ-027 winner_valid=1 only in ANSWER; winner holds last value otherwise.
REQ-028 REVEAL: start edge -> if q_index=NUM_Q-1 go DONE, else q_index+1, lockout cleared, QUESTION with cd_load pulse.
REQ-029 DONE: scores and q_index held; start edge -> IDLE (scores retained until next IDLE start).
REQ-030 Undefined state encodings -> IDLE next cycle.

Reset
REQ-031 reset low: state=IDLE, C_en=0, cd_load=0, winner=0, winner_valid=0, lockout=0, q_index=0, score=0, edge registers=0.
REQ-032 reset low mid-ANSWER or mid-QUESTION aborts round with no score update; first start edge after release starts new round.

Verification
REQ-033 Reset, start pulse -> state=1, cd_load=1 one cycle, then C_en=1, q_index=0.
REQ-034 In QUESTION buzz=4'b1010 rising same cycle -> state=2, winner=1, winner_valid=1, C_en=0; judge_ok -> s1=1, state=3.
REQ-035 Contestant 2 buzzes, judge_bad -> lockout=4'b0100, state=1, no cd_load; contestant 2 buzzes again -> ignored; contestant 0 buzzes -> winner=0.
REQ-036 Four successive buzz+judge_bad -> lockout=4'hF, state=3.
REQ-037 time_up=1 in QUESTION -> state=3; with NUM_Q=2, two questions then start -> state=4; start -> state=0.
REQ-038 s0 preloaded to 15 via repeated judge_ok (SCORE_W=4), one more judge_ok -> s0 stays 15; reset asserted in ANSWER -> all outputs zero asynchronously.
